lcd16x2_rx: RTL and testbench

//  Receiving end of the HD44780-style 8-bit LCD16x2 write bus (rs/e/data).

---
 rtl/lcd16x2_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd16x2_rx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd16x2_rx.sv
// lcd16x2_rx: receiving end of an HD44780-style 8-bit LCD write bus.
//   Synchronises rs/e/data, decodes each completed write (E falling edge) as an
//   instruction or a DDRAM data write, and keeps a 32-char DDRAM shadow plus the
//   display-control / entry-mode state.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   lcd_rs_i, lcd_e_i,     LCD bus inputs (asynchronous to clk_i)
//   lcd_data_i[7:0]
//   rd_addr_i[4:0]         shadow read address {line, col}
//   rd_char_o[7:0]         shadow char at rd_addr_i, 1-cycle latency
//   char_valid_o, char_o, char_pos_o   accepted data write
//   cmd_valid_o, cmd_o                 decoded instruction
//   disp_on_o, cursor_on_o, blink_o, incr_o   control state
//   busy_o                 clear sequence in progress
//   err_o                  short E, write while busy, or bad DDRAM address
// Output handshake: char_valid_o, cmd_valid_o and err_o are single-cycle valid
// pulses with no ready/backpressure; their payload (char_o, char_pos_o, cmd_o)
// is valid only in the cycle the pulse is high and holds its value afterwards.
module lcd16x2_rx #(
    parameter int          SYNC_STAGES = 2,
    parameter int          MIN_E_HIGH  = 2,
    parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       lcd_rs_i,
    input  logic       lcd_e_i,
    input  logic [7:0] lcd_data_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_char_o,
    output logic       char_valid_o,
    output logic [7:0] char_o,
    output logic [4:0] char_pos_o,
    output logic       cmd_valid_o,
    output logic [7:0] cmd_o,
    output logic       disp_on_o,
    output logic       cursor_on_o,
    output logic       blink_o,
    output logic       incr_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_EHIGH   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam int             CW      = (MIN_E_HIGH < 2) ? 1 : $clog2(MIN_E_HIGH + 1);
    localparam logic [CW-1:0]  MIN_CNT = CW'(MIN_E_HIGH);

    // Input synchronisers; rs and data share E's depth so they line up with it.
    logic [SYNC_STAGES-1:0] e_sync;
    logic [SYNC_STAGES-1:0] rs_sync;
    logic [7:0]             data_sync [SYNC_STAGES];
    logic                   e_s;
    logic                   rs_s;
    logic [7:0]             data_s;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            e_sync  <= '0;
            rs_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            e_sync       <= {e_sync[SYNC_STAGES-2:0], lcd_e_i};
            rs_sync      <= {rs_sync[SYNC_STAGES-2:0], lcd_rs_i};
            data_sync[0] <= lcd_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    assign e_s    = e_sync[SYNC_STAGES-1];
    assign rs_s   = rs_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    state_t          state;
    logic [4:0]      clr_idx;
    logic [CW-1:0]   e_cnt;
    logic            e_prev;
    logic            lat_rs;
    logic [7:0]      lat_data;
    logic [6:0]      ac;
    logic            ac_ok;
    logic [6:0]      ac_step;

    assign busy_o = (state == ST_CLEAR);

    // Only 0x00-0x0F and 0x40-0x4F map onto the 2x16 shadow.
    assign ac_ok = (ac[5:4] == 2'b00);

    // Address counter step wraps line 0 end -> line 1 start and line 1 end -> line 0.
    always_comb begin
        ac_step = ac;
        if (incr_o) begin
            if (ac == 7'h0F)      ac_step = 7'h40;
            else if (ac == 7'h4F) ac_step = 7'h00;
            else                  ac_step = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      ac_step = 7'h4F;
            else if (ac == 7'h40) ac_step = 7'h0F;
            else                  ac_step = ac - 7'd1;
        end
    end

    // DDRAM shadow: written by the clear sweep or by a legal data write.
    logic [7:0] mem [32];
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx;
        mem_wdata = CLEAR_CHAR;
        if (state == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (state == ST_CAPTURE && lat_rs && ac_ok) begin
            mem_we    = 1'b1;
            mem_waddr = {ac[6], ac[3:0]};
            mem_wdata = lat_data;
        end
    end

    // Read-before-write: a same-cycle write to the read cell returns old data.
    always_ff @(posedge clk_i) begin
        if (rst_ni && mem_we) mem[mem_waddr] <= mem_wdata;
        rd_char_o <= mem[rd_addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_CLEAR;
            clr_idx      <= '0;
            e_cnt        <= '0;
            e_prev       <= 1'b0;
            lat_rs       <= 1'b0;
            lat_data     <= '0;
            ac           <= '0;
            char_valid_o <= 1'b0;
            char_o       <= '0;
            char_pos_o   <= '0;
            cmd_valid_o  <= 1'b0;
            cmd_o        <= '0;
            disp_on_o    <= 1'b0;
            cursor_on_o  <= 1'b0;
            blink_o      <= 1'b0;
            incr_o       <= 1'b1;
            err_o        <= 1'b0;
        end else begin
            char_valid_o <= 1'b0;
            cmd_valid_o  <= 1'b0;
            err_o        <= 1'b0;
            e_prev       <= e_s;
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 5'd1;
                    // A write completing while busy is flagged and dropped.
                    if (e_prev && !e_s) err_o <= 1'b1;
                    if (clr_idx == 5'd31) begin
                        state <= ST_IDLE;
                        ac    <= '0;
                    end
                end
                ST_IDLE: begin
                    if (e_s) begin
                        state    <= ST_EHIGH;
                        e_cnt    <= CW'(1);
                        lat_rs   <= rs_s;
                        lat_data <= data_s;
                    end
                end
                ST_EHIGH: begin
                    if (e_s) begin
                        if (e_cnt != MIN_CNT) e_cnt <= e_cnt + 1'b1;
                        lat_rs   <= rs_s;
                        lat_data <= data_s;
                    end else if (e_cnt < MIN_CNT) begin
                        err_o <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                    if (!lat_rs) begin
                        cmd_valid_o <= 1'b1;
                        cmd_o       <= lat_data;
                        // Highest set bit selects the instruction.
                        casez (lat_data)
                            8'b1???????: ac <= lat_data[6:0];
                            8'b01??????: ;
                            8'b001?????: ;
                            8'b0001????: ;
                            8'b00001???: begin
                                disp_on_o   <= lat_data[2];
                                cursor_on_o <= lat_data[1];
                                blink_o     <= lat_data[0];
                            end
                            8'b000001??: incr_o <= lat_data[1];
                            8'b0000001?: ac <= '0;
                            8'b00000001: begin
                                ac      <= '0;
                                incr_o  <= 1'b1;
                                clr_idx <= '0;
                                state   <= ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end else if (ac_ok) begin
                        char_valid_o <= 1'b1;
                        char_o       <= lat_data;
                        char_pos_o   <= {ac[6], ac[3:0]};
                        ac           <= ac_step;
                    end else begin
                        err_o <= 1'b1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd16x2_rx.sv
// tb_lcd16x2_rx: stimulus drives LCD bus writes and pushes the expected output
// events into exp_q; a negedge monitor pops and compares whenever the DUT pulses.
module tb_lcd16x2_rx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       lcd_rs;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       char_valid;
    logic [7:0] char_o;
    logic [4:0] char_pos;
    logic       cmd_valid;
    logic [7:0] cmd_o;
    logic       disp_on;
    logic       cursor_on;
    logic       blink;
    logic       incr;
    logic       busy;
    logic       err;

    lcd16x2_rx dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .lcd_rs_i     (lcd_rs),
        .lcd_e_i      (lcd_e),
        .lcd_data_i   (lcd_data),
        .rd_addr_i    (rd_addr),
        .rd_char_o    (rd_char),
        .char_valid_o (char_valid),
        .char_o       (char_o),
        .char_pos_o   (char_pos),
        .cmd_valid_o  (cmd_valid),
        .cmd_o        (cmd_o),
        .disp_on_o    (disp_on),
        .cursor_on_o  (cursor_on),
        .blink_o      (blink),
        .incr_o       (incr),
        .busy_o       (busy),
        .err_o        (err)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    // event word: {kind[1:0], payload[13:0]}; 1 = char, 2 = cmd, 3 = err
    logic [15:0] exp_q[$];

    // reference model (AC kept as the raw 7-bit HD44780 address)
    logic [7:0] m_ddram [32];
    int         m_ac;
    bit         m_incr, m_disp, m_cur, m_blink;

    function automatic bit ac_legal(int a);
        return (a < 16) || (a >= 64 && a < 80);
    endfunction

    function automatic int ac_to_pos(int a);
        return (a >= 64) ? (a - 64 + 16) : a;
    endfunction

    function automatic int pos_to_ac(int p);
        return (p >= 16) ? (p - 16 + 64) : p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_event(input logic [15:0] act);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got %h expected none", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL event: got %h expected %h", act, e);
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (char_valid) check_event({2'd1, 1'b0, char_pos, char_o});
            if (cmd_valid)  check_event({2'd2, 6'd0, cmd_o});
            if (err)        check_event({2'd3, 14'd0});
        end
    end

    // ---------------- model ----------------
    task automatic model_clear();
        for (int p = 0; p < 32; p++) m_ddram[p] = 8'h20;
        m_ac   = 0;
        m_incr = 1'b1;
    endtask

    task automatic model_op(input bit rs, input logic [7:0] d, input int width);
        int hb;
        int pos;
        if (width < 2) begin
            exp_q.push_back({2'd3, 14'd0});
        end else if (!rs) begin
            exp_q.push_back({2'd2, 6'd0, d});
            hb = -1;
            for (int i = 0; i < 8; i++) if (d[i]) hb = i;
            case (hb)
                7: m_ac = int'(d[6:0]);
                3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
                2: m_incr = d[1];
                1: m_ac = 0;
                0: model_clear();
                default: ;
            endcase
        end else if (ac_legal(m_ac)) begin
            pos = ac_to_pos(m_ac);
            exp_q.push_back({2'd1, 1'b0, 5'(pos), d});
            m_ddram[pos] = d;
            m_ac = pos_to_ac((pos + (m_incr ? 1 : 31)) % 32);
        end else begin
            exp_q.push_back({2'd3, 14'd0});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_pulse(input bit rs, input logic [7:0] d, input int width);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_data = d;
        lcd_e    = 1'b1;
        repeat (width) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_end", busy, 0);
    endtask

    task automatic bus_write(input bit rs, input logic [7:0] d, input int width);
        model_op(rs, d, width);
        bus_pulse(rs, d, width);
        repeat (8) @(negedge clk);
        wait_not_busy();
    endtask

    task automatic count_busy(input string name);
        int cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check(name, cnt, 32);
    endtask

    task automatic wait_busy_rise();
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_rise", busy, 1);
    endtask

    task automatic do_reset(input bit check_vals);
        @(negedge clk);
        rst_n = 1'b0;
        lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        if (check_vals) begin
            check("rst_char_valid", char_valid, 0);
            check("rst_cmd_valid", cmd_valid, 0);
            check("rst_err", err, 0);
            check("rst_char", char_o, 0);
            check("rst_cmd", cmd_o, 0);
            check("rst_pos", char_pos, 0);
            check("rst_disp", disp_on, 0);
            check("rst_cursor", cursor_on, 0);
            check("rst_blink", blink, 0);
            check("rst_incr", incr, 1);
            check("rst_busy", busy, 1);
        end
        model_clear();
        m_disp  = 1'b0;
        m_cur   = 1'b0;
        m_blink = 1'b0;
        rst_n   = 1'b1;
        count_busy("reset_busy_len");
    endtask

    task automatic check_ddram(input string tag);
        for (int p = 0; p < 32; p++) begin
            rd_addr = 5'(p);
            @(negedge clk);
            check($sformatf("rd_%s_%0d", tag, p), rd_char, m_ddram[p]);
        end
    endtask

    task automatic check_ctrl(input string tag);
        check({"disp_", tag}, disp_on, m_disp);
        check({"cursor_", tag}, cursor_on, m_cur);
        check({"blink_", tag}, blink, m_blink);
        check({"incr_", tag}, incr, m_incr);
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- main stimulus ----------------
    initial begin
        string s;
        bit          rs;
        logic [7:0]  d;
        int          w;
        int          r;

        rst_n    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_e    = 1'b0;
        lcd_data = 8'h00;
        rd_addr  = 5'd0;
        m_disp   = 1'b0;
        m_cur    = 1'b0;
        m_blink  = 1'b0;
        model_clear();

        do_reset(1'b1);
        check_ddram("post_reset");
        check_ctrl("post_reset");

        // first char at AC=0
        bus_write(1'b1, 8'h48, 4);

        // line 1 fill and wrap to line 0
        bus_write(1'b0, 8'hC0, 4);
        s = "0123456789ABCDEF";
        for (int i = 0; i < 16; i++) bus_write(1'b1, s[i], 3);
        bus_write(1'b1, 8'h47, 3);

        // decrement mode wraps from 0x00 to 0x4F
        bus_write(1'b0, 8'h04, 4);
        bus_write(1'b0, 8'h80, 4);
        bus_write(1'b1, 8'h41, 4);
        bus_write(1'b1, 8'h42, 4);
        check_ctrl("decr");
        bus_write(1'b0, 8'h06, 2);

        // short E, and a write to an unmapped address
        bus_write(1'b1, 8'h55, 1);
        bus_write(1'b0, 8'h90, 4);
        bus_write(1'b1, 8'h33, 4);
        check_ddram("after_err");

        bus_write(1'b0, 8'h0F, 4);
        check("disp_on_0f", disp_on, 1);
        check("cursor_on_0f", cursor_on, 1);
        check("blink_0f", blink, 1);

        // clear instruction: 32 busy cycles
        model_op(1'b0, 8'h01, 4);
        bus_pulse(1'b0, 8'h01, 4);
        wait_busy_rise();
        count_busy("clear_busy_len");
        check_ddram("after_clear");

        // data write during busy is flagged and dropped
        bus_write(1'b1, 8'h61, 4);
        model_op(1'b0, 8'h01, 4);
        bus_pulse(1'b0, 8'h01, 4);
        wait_busy_rise();
        repeat (4) @(negedge clk);
        exp_q.push_back({2'd3, 14'd0});
        bus_pulse(1'b1, 8'h62, 3);
        repeat (4) @(negedge clk);
        wait_not_busy();
        repeat (8) @(negedge clk);
        check_ddram("busy_write");

        // reset in the middle of a clear restarts the full sweep
        bus_write(1'b1, 8'h63, 4);
        model_op(1'b0, 8'h01, 4);
        bus_pulse(1'b0, 8'h01, 4);
        wait_busy_rise();
        repeat (10) @(negedge clk);
        do_reset(1'b0);
        check_ddram("mid_reset");
        check_ctrl("mid_reset");

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                d = 8'($urandom_range(0, 255));
            end else begin
                r = $urandom_range(0, 9);
                case (r)
                    0: d = 8'h80 | 8'(pos_to_ac($urandom_range(0, 31)));
                    1: d = 8'h80 | 8'($urandom_range(0, 127));
                    2: d = 8'h08 | 8'($urandom_range(0, 7));
                    3: d = 8'h04 | 8'($urandom_range(0, 3));
                    4: d = 8'h02 | 8'($urandom_range(0, 1));
                    5: d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
                    6: d = 8'h20 | 8'($urandom_range(0, 31));
                    default: d = 8'($urandom_range(0, 255));
                endcase
            end
            w = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 5);
            bus_write(rs, d, w);
            check_ctrl("rand");
        end
        check_ddram("final");

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
